// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing arithmetic,
// common to the transmitter and receiver.
package uart_pkg;

   // Frame FSM states; encoding is fixed so both directions decode it alike.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SEND  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Clock cycles per line bit, computed in integer nanoseconds so that the
   // transmitter and receiver round the same way.
   function automatic int calc_cycles_per_bit(input int bit_rate, input int clk_hz);
      return (1000000000 / bit_rate) / (1000000000 / clk_hz);
   endfunction

   // Width of the cycle counter; one spare bit above what the count needs.
   function automatic int calc_count_reg_len(input int cycles_per_bit);
      return 1 + $clog2(cycles_per_bit);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request/status bundle of the UART transmitter plus the
// serial pin. The master is the packet/command logic; the slave is uart_tx.
interface uart_tx_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    uart_tx_en;
   logic [PAYLOAD_BITS-1:0] uart_tx_data;
   logic                    uart_tx_busy;
   logic                    uart_tx_done;
   logic                    uart_txd;

   modport master (
      output uart_tx_en,
      output uart_tx_data,
      input  uart_tx_busy,
      input  uart_tx_done,
      input  uart_txd
   );

   modport slave (
      input  uart_tx_en,
      input  uart_tx_data,
      output uart_tx_busy,
      output uart_tx_done,
      output uart_txd
   );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles within one line bit and flags the
// last cycle of each bit. Held at zero while disabled, so the first bit after
// enabling is a full period long.
module uart_bit_timer #(
   parameter int CYCLES_PER_BIT = 100,
   parameter int COUNT_REG_LEN  = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_en,
   output logic [COUNT_REG_LEN-1:0] o_count,
   output logic                     o_bit_end
);

   localparam logic [COUNT_REG_LEN-1:0] LAST_CYCLE = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);

   logic [COUNT_REG_LEN-1:0] r_count;
   logic                     w_last;

   assign w_last    = (r_count == LAST_CYCLE);
   assign o_count   = r_count;
   assign o_bit_end = i_en && w_last;

   // Cycle counter: 0..CYCLES_PER_BIT-1, wrapping at each bit boundary.
   always_ff @(posedge clk) begin
      if (!resetn || !i_en) begin
         r_count <= '0;
      end else if (w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + COUNT_REG_LEN'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one payload word per accepted request as
// start bit (0), data LSB first, then STOP_BITS stop bits (1). The line idles
// high and is driven straight from a flop. Requests while busy are dropped.
// CYCLES_PER_BIT must be at least 2 (the done pulse is registered one cycle
// ahead of the final stop cycle).
module uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 100000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic      clk,
   input  logic      resetn,
   uart_tx_if.slave  tx_if
);

   localparam int CYCLES_PER_BIT = calc_cycles_per_bit(BIT_RATE, CLK_HZ);
   localparam int COUNT_REG_LEN  = calc_count_reg_len(CYCLES_PER_BIT);
   localparam int BIT_CNT_W      = $clog2(PAYLOAD_BITS + 1);

   localparam logic [COUNT_REG_LEN-1:0] CNT_PRE_END = COUNT_REG_LEN'(CYCLES_PER_BIT - 2);
   localparam logic [BIT_CNT_W-1:0]     LAST_DATA   = BIT_CNT_W'(PAYLOAD_BITS - 1);
   localparam logic [BIT_CNT_W-1:0]     LAST_STOP   = BIT_CNT_W'(STOP_BITS - 1);

   uart_state_t              r_state;
   logic [PAYLOAD_BITS-1:0]  r_shift;
   logic [BIT_CNT_W-1:0]     r_bit_cnt;
   logic                     r_txd;
   logic                     r_busy;
   logic                     r_done;

   logic                     w_timer_en;
   logic [COUNT_REG_LEN-1:0] w_count;
   logic                     w_bit_end;
   logic [PAYLOAD_BITS-1:0]  w_shift_next;

   assign w_timer_en   = (r_state != IDLE);
   assign w_shift_next = r_shift >> 1;

   uart_bit_timer #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT),
      .COUNT_REG_LEN  (COUNT_REG_LEN)
   ) u_bit_timer (
      .clk       (clk),
      .resetn    (resetn),
      .i_en      (w_timer_en),
      .o_count   (w_count),
      .o_bit_end (w_bit_end)
   );

   // Frame FSM: every output is set one edge ahead so the pin, busy and done
   // all come straight from flops.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_txd     <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_txd     <= 1'b1;
               r_busy    <= 1'b0;
               r_bit_cnt <= '0;
               if (tx_if.uart_tx_en) begin
                  r_shift <= tx_if.uart_tx_data;
                  r_state <= START;
                  r_txd   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state   <= SEND;
                  r_txd     <= r_shift[0];
                  r_bit_cnt <= '0;
               end
            end
            SEND: begin
               if (w_bit_end) begin
                  r_shift <= w_shift_next;
                  if (r_bit_cnt == LAST_DATA) begin
                     r_state   <= STOP;
                     r_txd     <= 1'b1;
                     r_bit_cnt <= '0;
                  end else begin
                     r_txd     <= w_shift_next[0];
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end
            STOP: begin
               // Raise done so it lands on the last cycle of the last stop bit.
               if (r_bit_cnt == LAST_STOP && w_count == CNT_PRE_END) begin
                  r_done <= 1'b1;
               end
               if (w_bit_end) begin
                  if (r_bit_cnt == LAST_STOP) begin
                     r_state   <= IDLE;
                     r_busy    <= 1'b0;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx_if.uart_txd     = r_txd;
   assign tx_if.uart_tx_busy = r_busy;
   assign tx_if.uart_tx_done = r_done;

endmodule
